// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the 6502 ALU sequencer.
// Holds the ALU op encodings, the command enum seen on req_cmd, the FSM
// state codes and the N/V/Z/C flag bundle.
// Optional build macro referenced by users of this package: DECIMAL_MODE_EN.
package alu_pkg;

  localparam logic [3:0] ALU_OP_NONE = 4'd0;
  localparam logic [3:0] ALU_SUM     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_EOR     = 4'd3;
  localparam logic [3:0] ALU_OR      = 4'd4;
  localparam logic [3:0] ALU_SR      = 4'd5;
  localparam logic [3:0] ALU_ROR     = 4'd6;

  typedef enum logic [3:0] {
    CMD_ADC = 4'd0,
    CMD_SBC = 4'd1,
    CMD_CMP = 4'd2,
    CMD_AND = 4'd3,
    CMD_ORA = 4'd4,
    CMD_EOR = 4'd5,
    CMD_LDA = 4'd6,
    CMD_ASL = 4'd7,
    CMD_ROL = 4'd8,
    CMD_LSR = 4'd9,
    CMD_ROR = 4'd10,
    CMD_CLC = 4'd11,
    CMD_SEC = 4'd12,
    CMD_CLV = 4'd13,
    CMD_SED = 4'd14,
    CMD_CLD = 4'd15
  } cmd_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;
  localparam state_t ST_ADJ  = 2'd3;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu_sequencer_flag_unit.sv
// alu_flag_unit: per-command accumulator write enable and next flag values.
// Purely combinational; the sequencer registers the outputs at the end of EXEC.
// Ports:
//   cmd           latched command
//   flags         current N/V/Z/C
//   alu_sign      ALU result bit 7
//   alu_carry_out, alu_zero, alu_overflow  ALU status
//   flag_d / flag_d_nxt  decimal flag in/out (DECIMAL_MODE_EN builds only)
//   acc_we        accumulator takes the ALU result
//   flags_nxt     flag values to register
//   illegal       command code outside the set decoded by this build
// Build macro: DECIMAL_MODE_EN adds SED/CLD handling.
module alu_flag_unit
  import alu_pkg::*;
(
  input  cmd_e   cmd,
  input  flags_t flags,
  input  logic   alu_sign,
  input  logic   alu_carry_out,
  input  logic   alu_zero,
  input  logic   alu_overflow,
`ifdef DECIMAL_MODE_EN
  input  logic   flag_d,
  output logic   flag_d_nxt,
`endif
  output logic   acc_we,
  output flags_t flags_nxt,
  output logic   illegal
);

  always_comb begin
    acc_we    = 1'b0;
    flags_nxt = flags;
    illegal   = 1'b0;
`ifdef DECIMAL_MODE_EN
    flag_d_nxt = flag_d;
`endif
    case (cmd)
      CMD_ADC, CMD_SBC: begin
        acc_we      = 1'b1;
        flags_nxt.n = alu_sign;
        flags_nxt.v = alu_overflow;
        flags_nxt.z = alu_zero;
        flags_nxt.c = alu_carry_out;
      end
      CMD_CMP: begin
        flags_nxt.n = alu_sign;
        flags_nxt.z = alu_zero;
        flags_nxt.c = alu_carry_out;
      end
      CMD_AND, CMD_ORA, CMD_EOR, CMD_LDA: begin
        acc_we      = 1'b1;
        flags_nxt.n = alu_sign;
        flags_nxt.z = alu_zero;
      end
      CMD_ASL, CMD_ROL, CMD_ROR: begin
        acc_we      = 1'b1;
        flags_nxt.n = alu_sign;
        flags_nxt.z = alu_zero;
        flags_nxt.c = alu_carry_out;
      end
      CMD_LSR: begin
        acc_we      = 1'b1;
        flags_nxt.n = 1'b0;
        flags_nxt.z = alu_zero;
        flags_nxt.c = alu_carry_out;
      end
      CMD_CLC: flags_nxt.c = 1'b0;
      CMD_SEC: flags_nxt.c = 1'b1;
      CMD_CLV: flags_nxt.v = 1'b0;
`ifdef DECIMAL_MODE_EN
      CMD_SED: flag_d_nxt = 1'b1;
      CMD_CLD: flag_d_nxt = 1'b0;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: control front end for the 6502 datapath ALU. Owns the
// accumulator and N/V/Z/C, accepts one command per handshake, drives the
// external combinational ALU for one cycle and captures its result.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        command handshake (ready only in IDLE)
//   req_cmd, req_operand       command code and memory operand
//   alu_a, alu_b, alu_op, alu_inverted, alu_carry_in   ALU drive
//   alu_out, alu_carry_out, alu_zero, alu_overflow     ALU result
//   resp_valid/resp_ready      response handshake, resp_err = illegal cmd
//   acc, flag_n/v/z/c          architectural state (flag_d with macro)
// Build macro: DECIMAL_MODE_EN adds flag_d, SED/CLD and the ADJ state.
//
// state | meaning
// IDLE  | waiting for a command, req_ready high
// EXEC  | ALU driven from latched cmd/operand, result captured at edge
// ADJ   | decimal ADC/SBC: binary result re-issued with BCD correction
// RESP  | resp_valid high, acc/flags final, wait for resp_ready
module alu_sequencer
  import alu_pkg::*;
#(
  parameter logic [7:0] ACC_RESET = 8'h00,
  parameter logic [3:0] OP_NONE   = ALU_OP_NONE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_cmd,
  input  logic [7:0] req_operand,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_inverted,
  output logic       alu_carry_in,
  input  logic [7:0] alu_out,
  input  logic       alu_carry_out,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_err,
  output logic [7:0] acc,
  output logic       flag_n,
  output logic       flag_v,
  output logic       flag_z,
`ifdef DECIMAL_MODE_EN
  output logic       flag_d,
`endif
  output logic       flag_c
);

  state_t     state;
  cmd_e       cmd_q;
  logic [7:0] opnd_q;
  flags_t     flags;
  flags_t     flags_nxt;
  logic       acc_we;
  logic       illegal;

`ifdef DECIMAL_MODE_EN
  logic       d_q;
  logic       d_nxt;
  logic [7:0] corr_q;
  logic       dec_c_q;
  logic [4:0] lo_sum;
  logic       lo_fix;
  logic       hi_fix;
  logic       dec_c_nxt;
  logic       dec_adj;
  logic [7:0] corr_nxt;
`endif

  alu_flag_unit u_flag_unit (
    .cmd           (cmd_q),
    .flags         (flags),
    .alu_sign      (alu_out[7]),
    .alu_carry_out (alu_carry_out),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
`ifdef DECIMAL_MODE_EN
    .flag_d        (d_q),
    .flag_d_nxt    (d_nxt),
`endif
    .acc_we        (acc_we),
    .flags_nxt     (flags_nxt),
    .illegal       (illegal)
  );

`ifdef DECIMAL_MODE_EN
  // BCD correction derived during EXEC from the pre-update accumulator and
  // the binary ALU result; it is applied through the ALU in ADJ.
  always_comb begin
    lo_sum  = {1'b0, acc[3:0]} + {1'b0, opnd_q[3:0]} + {4'd0, flags.c};
    dec_adj = d_q && ((cmd_q == CMD_ADC) || (cmd_q == CMD_SBC));
    if (cmd_q == CMD_SBC) begin
      lo_fix    = {1'b0, acc[3:0]} < ({1'b0, opnd_q[3:0]} + {4'd0, ~flags.c});
      hi_fix    = ~alu_carry_out;
      dec_c_nxt = alu_carry_out;
    end else begin
      lo_fix    = lo_sum > 5'd9;
      hi_fix    = {alu_carry_out, alu_out} > 9'h099;
      dec_c_nxt = hi_fix;
    end
    corr_nxt = {(hi_fix ? 4'h6 : 4'h0), (lo_fix ? 4'h6 : 4'h0)};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      acc    <= ACC_RESET;
      flags  <= '0;
      cmd_q  <= CMD_ADC;
      opnd_q <= 8'h00;
`ifdef DECIMAL_MODE_EN
      d_q     <= 1'b0;
      corr_q  <= 8'h00;
      dec_c_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_q  <= cmd_e'(req_cmd);
            opnd_q <= req_operand;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (acc_we) acc <= alu_out;
          flags <= flags_nxt;
`ifdef DECIMAL_MODE_EN
          d_q <= d_nxt;
          if (dec_adj) begin
            corr_q  <= corr_nxt;
            dec_c_q <= dec_c_nxt;
            state   <= ST_ADJ;
          end else begin
            state <= ST_RESP;
          end
`else
          state <= ST_RESP;
`endif
        end
`ifdef DECIMAL_MODE_EN
        ST_ADJ: begin
          acc     <= alu_out;
          flags.c <= dec_c_q;
          state   <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_op       = OP_NONE;
    alu_inverted = 1'b0;
    alu_carry_in = 1'b0;
    if (state == ST_EXEC) begin
      case (cmd_q)
        CMD_ADC: begin
          alu_a = acc; alu_b = opnd_q; alu_op = ALU_SUM;
          alu_carry_in = flags.c;
        end
        CMD_SBC: begin
          alu_a = acc; alu_b = opnd_q; alu_op = ALU_SUM;
          alu_inverted = 1'b1; alu_carry_in = flags.c;
        end
        CMD_CMP: begin
          alu_a = acc; alu_b = opnd_q; alu_op = ALU_SUM;
          alu_inverted = 1'b1; alu_carry_in = 1'b1;
        end
        CMD_AND: begin alu_a = acc; alu_b = opnd_q; alu_op = ALU_AND; end
        CMD_ORA: begin alu_a = acc; alu_b = opnd_q; alu_op = ALU_OR;  end
        CMD_EOR: begin alu_a = acc; alu_b = opnd_q; alu_op = ALU_EOR; end
        CMD_LDA: begin alu_a = opnd_q; alu_op = ALU_OR; end
        // Shifts left are acc + acc so the ALU carry out is the old bit 7.
        CMD_ASL: begin alu_a = acc; alu_b = acc; alu_op = ALU_SUM; end
        CMD_ROL: begin
          alu_a = acc; alu_b = acc; alu_op = ALU_SUM;
          alu_carry_in = flags.c;
        end
        CMD_LSR: begin alu_a = acc; alu_op = ALU_SR; end
        CMD_ROR: begin
          alu_a = acc; alu_op = ALU_ROR; alu_carry_in = flags.c;
        end
        default: ;
      endcase
    end
`ifdef DECIMAL_MODE_EN
    else if (state == ST_ADJ) begin
      alu_a        = acc;
      alu_b        = corr_q;
      alu_op       = ALU_SUM;
      alu_inverted = (cmd_q == CMD_SBC);
      alu_carry_in = (cmd_q == CMD_SBC);
    end
`endif
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && illegal;
  assign flag_n     = flags.n;
  assign flag_v     = flags.v;
  assign flag_z     = flags.z;
  assign flag_c     = flags.c;
`ifdef DECIMAL_MODE_EN
  assign flag_d     = d_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: an abstract 6502 model predicts
// acc/flags per command, a behavioural ALU answers the DUT's drive, and a
// negedge compare process checks outputs whenever the DUT is idle or
// responding. Decimal tests are built only with DECIMAL_MODE_EN.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_cmd;
  logic [7:0] req_operand;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_op;
  logic       alu_inverted, alu_carry_in, alu_carry_out, alu_zero, alu_overflow;
  logic       resp_valid, resp_ready, resp_err;
  logic [7:0] acc;
  logic       flag_n, flag_v, flag_z, flag_c;
`ifdef DECIMAL_MODE_EN
  logic       flag_d;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit run_cmp = 0;

  logic [7:0] exp_acc;
  logic       exp_n, exp_v, exp_z, exp_c, exp_d, exp_err;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_operand(req_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_inverted(alu_inverted), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .acc(acc), .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z),
`ifdef DECIMAL_MODE_EN
    .flag_d(flag_d),
`endif
    .flag_c(flag_c)
  );

  // Behavioural combinational ALU
  logic [7:0] b_eff;
  logic [8:0] s_alu;
  always_comb begin
    b_eff = alu_inverted ? ~alu_b : alu_b;
    s_alu = {1'b0, alu_a} + {1'b0, b_eff} + {8'd0, alu_carry_in};
    alu_out = 8'h00;
    alu_carry_out = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'd1: begin
        alu_out = s_alu[7:0];
        alu_carry_out = s_alu[8];
        alu_overflow = (alu_a[7] == b_eff[7]) && (s_alu[7] != alu_a[7]);
      end
      4'd2: alu_out = alu_a & b_eff;
      4'd3: alu_out = alu_a ^ b_eff;
      4'd4: alu_out = alu_a | b_eff;
      4'd5: begin alu_out = {1'b0, alu_a[7:1]}; alu_carry_out = alu_a[0]; end
      4'd6: begin alu_out = {alu_carry_in, alu_a[7:1]}; alu_carry_out = alu_a[0]; end
      default: ;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

`ifdef DECIMAL_MODE_EN
  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
  function automatic logic [7:0] int2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction
`endif

  // Architectural effect of one command, from the 6502 arithmetic rules.
  task automatic model_apply(input logic [3:0] cmd, input logic [7:0] op);
    int s, ss, sa, sb, ds;
    logic [7:0] r;
    sa = $signed(exp_acc);
    sb = $signed(op);
    exp_err = 1'b0;
    case (cmd)
      CMD_ADC: begin
        s  = int'(exp_acc) + int'(op) + int'(exp_c);
        ss = sa + sb + int'(exp_c);
        r  = 8'(s);
        exp_n = r[7]; exp_z = (r == 0); exp_v = (ss > 127) || (ss < -128);
`ifdef DECIMAL_MODE_EN
        if (exp_d) begin
          ds = bcd2int(exp_acc) + bcd2int(op) + int'(exp_c);
          exp_c = (ds > 99);
          exp_acc = int2bcd(ds % 100);
        end else begin
          exp_c = (s > 255); exp_acc = r;
        end
`else
        exp_c = (s > 255); exp_acc = r;
`endif
      end
      CMD_SBC: begin
        s  = int'(exp_acc) - int'(op) - (1 - int'(exp_c));
        ss = sa - sb - (1 - int'(exp_c));
        r  = 8'(s);
        exp_n = r[7]; exp_z = (r == 0); exp_v = (ss > 127) || (ss < -128);
`ifdef DECIMAL_MODE_EN
        if (exp_d) begin
          ds = bcd2int(exp_acc) - bcd2int(op) - (1 - int'(exp_c));
          exp_c = (ds >= 0);
          exp_acc = int2bcd((ds + 100) % 100);
        end else begin
          exp_c = (s >= 0); exp_acc = r;
        end
`else
        exp_c = (s >= 0); exp_acc = r;
`endif
      end
      CMD_CMP: begin
        r = exp_acc - op;
        exp_n = r[7]; exp_z = (r == 0); exp_c = (exp_acc >= op);
      end
      CMD_AND: begin exp_acc = exp_acc & op; exp_n = exp_acc[7]; exp_z = (exp_acc == 0); end
      CMD_ORA: begin exp_acc = exp_acc | op; exp_n = exp_acc[7]; exp_z = (exp_acc == 0); end
      CMD_EOR: begin exp_acc = exp_acc ^ op; exp_n = exp_acc[7]; exp_z = (exp_acc == 0); end
      CMD_LDA: begin exp_acc = op; exp_n = exp_acc[7]; exp_z = (exp_acc == 0); end
      CMD_ASL: begin
        exp_c = exp_acc[7]; exp_acc = exp_acc << 1;
        exp_n = exp_acc[7]; exp_z = (exp_acc == 0);
      end
      CMD_ROL: begin
        r = {exp_acc[6:0], exp_c}; exp_c = exp_acc[7]; exp_acc = r;
        exp_n = exp_acc[7]; exp_z = (exp_acc == 0);
      end
      CMD_LSR: begin
        exp_c = exp_acc[0]; exp_acc = exp_acc >> 1;
        exp_n = 1'b0; exp_z = (exp_acc == 0);
      end
      CMD_ROR: begin
        r = {exp_c, exp_acc[7:1]}; exp_c = exp_acc[0]; exp_acc = r;
        exp_n = exp_acc[7]; exp_z = (exp_acc == 0);
      end
      CMD_CLC: exp_c = 1'b0;
      CMD_SEC: exp_c = 1'b1;
      CMD_CLV: exp_v = 1'b0;
`ifdef DECIMAL_MODE_EN
      CMD_SED: exp_d = 1'b1;
      CMD_CLD: exp_d = 1'b0;
`endif
      default: exp_err = 1'b1;
    endcase
  endtask

  task automatic model_reset();
    exp_acc = 8'h00; exp_n = 0; exp_v = 0; exp_z = 0; exp_c = 0; exp_d = 0; exp_err = 0;
  endtask

  always @(negedge clk) begin
    if (run_cmp && rst_n && (resp_valid || req_ready)) begin
      check("acc", acc, exp_acc);
      check("flag_n", flag_n, exp_n);
      check("flag_v", flag_v, exp_v);
      check("flag_z", flag_z, exp_z);
      check("flag_c", flag_c, exp_c);
`ifdef DECIMAL_MODE_EN
      check("flag_d", flag_d, exp_d);
`endif
      check("resp_err", resp_err, resp_valid ? 32'(exp_err) : 32'd0);
      check("alu_op quiet", alu_op, 4'd0);
    end
  end

  // Issues one command; returns on a negedge while the response is shown.
  task automatic do_cmd(input logic [3:0] cmd, input logic [7:0] op, input int hold, input string nm);
    int lat, exp_lat, guard;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    check({nm, " ready"}, req_ready, 1);
    exp_lat = ((cmd == CMD_ADC || cmd == CMD_SBC) && exp_d) ? 3 : 2;
    req_cmd = cmd; req_operand = op; req_valid = 1'b1; resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_apply(cmd, op);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 10);
    check({nm, " latency"}, lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      check({nm, " bp resp_valid"}, resp_valid, 1);
      check({nm, " bp req_ready"}, req_ready, 0);
      req_valid = 1'b1; req_cmd = CMD_LDA; req_operand = 8'h77;
      @(negedge clk);
    end
    if (hold > 0) begin
      req_valid = 1'b0; resp_ready = 1'b1;
      check({nm, " bp still valid"}, resp_valid, 1);
    end
  endtask

  task automatic lits(input string nm, input logic [7:0] a, input logic n, input logic v,
                      input logic z, input logic c);
    check({nm, " lit acc"}, acc, a);
    check({nm, " lit N"}, flag_n, n);
    check({nm, " lit V"}, flag_v, v);
    check({nm, " lit Z"}, flag_z, z);
    check({nm, " lit C"}, flag_c, c);
  endtask

  logic [3:0] vec_cmd [10] = '{CMD_LDA, CMD_AND, CMD_ORA, CMD_EOR, CMD_ASL,
                               CMD_ROL, CMD_CLC, CMD_ROL, CMD_SEC, CMD_CLV};
  logic [7:0] vec_op  [10] = '{8'hF0, 8'h3C, 8'h0F, 8'hFF, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_cmd = 0; req_operand = 0; resp_ready = 1; rst_n = 1;
    model_reset();
    #2 rst_n = 0;
    #1;
    lits("reset", 8'h00, 0, 0, 0, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset req_ready", req_ready, 1);
    check("reset alu_op", alu_op, 4'd0);
    check("reset alu_a", alu_a, 8'h00);
    @(negedge clk); @(negedge clk);
    rst_n = 1; run_cmp = 1;
    @(negedge clk);

    do_cmd(CMD_LDA, 8'h50, 0, "lda50");
    do_cmd(CMD_CLC, 8'h00, 0, "clc");
    do_cmd(CMD_ADC, 8'h50, 0, "adc");
    lits("adc", 8'hA0, 1, 1, 0, 0);

    do_cmd(CMD_LDA, 8'h00, 0, "lda00");
    do_cmd(CMD_SEC, 8'h00, 0, "sec");
    do_cmd(CMD_SBC, 8'h01, 0, "sbc");
    lits("sbc", 8'hFF, 1, 0, 0, 0);

    do_cmd(CMD_LDA, 8'h40, 0, "lda40");
    do_cmd(CMD_CMP, 8'h40, 0, "cmp");
    lits("cmp", 8'h40, 0, 0, 1, 1);

    do_cmd(CMD_LDA, 8'h01, 0, "lda01");
    do_cmd(CMD_SEC, 8'h00, 0, "sec");
    do_cmd(CMD_ROR, 8'hAA, 0, "ror");
    lits("ror", 8'h80, 1, 0, 0, 1);

    do_cmd(CMD_LDA, 8'h01, 0, "lda01");
    do_cmd(CMD_LSR, 8'h55, 0, "lsr");
    lits("lsr", 8'h00, 0, 0, 1, 1);

    for (int i = 0; i < 10; i++) do_cmd(vec_cmd[i], vec_op[i], 0, "vec");
    do_cmd(CMD_LDA, 8'h80, 0, "lda80");
    do_cmd(CMD_SEC, 8'h00, 0, "sec");
    do_cmd(CMD_SBC, 8'h01, 0, "sbc_ovf");
    lits("sbc_ovf", 8'h7F, 0, 1, 0, 1);
    do_cmd(CMD_CLV, 8'h00, 0, "clv");

    do_cmd(CMD_LDA, 8'h11, 0, "lda11");
    do_cmd(CMD_CLC, 8'h00, 0, "clc");
    do_cmd(CMD_ADC, 8'h22, 3, "adc_bp");
    lits("adc_bp", 8'h33, 0, 0, 0, 0);

    // Reset in the middle of EXEC drops the command.
    do_cmd(CMD_LDA, 8'h5A, 0, "lda5a");
    do_cmd(CMD_SEC, 8'h00, 0, "sec");
    @(negedge clk);
    req_cmd = CMD_ADC; req_operand = 8'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 0;
    model_reset();
    #1;
    lits("midrst", 8'h00, 0, 0, 0, 0);
    check("midrst req_ready", req_ready, 1);
    check("midrst alu_op", alu_op, 4'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst no resp", resp_valid, 0);
    end

`ifndef DECIMAL_MODE_EN
    do_cmd(CMD_LDA, 8'h3C, 0, "lda3c");
    do_cmd(CMD_SEC, 8'h00, 0, "sec");
    do_cmd(4'd14, 8'hFF, 0, "illegal");
    check("illegal lit err", resp_err, 1);
    lits("illegal", 8'h3C, 0, 0, 0, 1);
`else
    do_cmd(CMD_SED, 8'h00, 0, "sed");
    check("sed lit D", flag_d, 1);
    do_cmd(CMD_CLC, 8'h00, 0, "clc");
    do_cmd(CMD_LDA, 8'h09, 0, "lda09");
    do_cmd(CMD_ADC, 8'h01, 0, "dadc");
    check("dadc lit acc", acc, 8'h10);
    check("dadc lit C", flag_c, 0);
    do_cmd(CMD_LDA, 8'h99, 0, "lda99");
    do_cmd(CMD_CLC, 8'h00, 0, "clc");
    do_cmd(CMD_ADC, 8'h01, 0, "dadc99");
    check("dadc99 lit acc", acc, 8'h00);
    check("dadc99 lit C", flag_c, 1);
    do_cmd(CMD_LDA, 8'h10, 0, "lda10");
    do_cmd(CMD_SEC, 8'h00, 0, "sec");
    do_cmd(CMD_SBC, 8'h01, 0, "dsbc");
    check("dsbc lit acc", acc, 8'h09);
    check("dsbc lit C", flag_c, 1);
    do_cmd(CMD_CLD, 8'h00, 0, "cld");
`endif

    @(negedge clk); @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
